// File: rtl/g_alu_pkg.sv
// g_alu_pkg: shared widths and state encoding for the sequential ALU ops
package g_alu_pkg;
  localparam int ALU_W = 32;
  localparam int MUL_CNT_W = 5;
  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
endpackage

// File: rtl/G_FullAdder32.sv
// G_FullAdder32: 32-bit adder built from 4-bit carry-lookahead groups
import g_alu_pkg::*;
module G_FullAdder32 (
  input  logic [ALU_W-1:0] In1,
  input  logic [ALU_W-1:0] In2,
  input  logic             CI,
  input  logic             Enable,
  output logic [ALU_W-1:0] Sum,
  output logic             CO
);
  logic [ALU_W-1:0] g, p;
  logic [ALU_W:0] c;
  assign g = In1 & In2;
  assign p = In1 ^ In2;
  assign c[0] = CI;
  for (genvar b = 0; b < ALU_W / 4; b++) begin : g_grp
    logic [3:0] gg, pp;
    logic ci;
    assign gg = g[4*b +: 4];
    assign pp = p[4*b +: 4];
    assign ci = c[4*b];
    assign c[4*b+1] = gg[0] | (pp[0] & ci);
    assign c[4*b+2] = gg[1] | (pp[1] & gg[0]) | (&pp[1:0] & ci);
    assign c[4*b+3] = gg[2] | (pp[2] & gg[1]) | (&pp[2:1] & gg[0]) | (&pp[2:0] & ci);
    assign c[4*b+4] = gg[3] | (pp[3] & gg[2]) | (&pp[3:2] & gg[1]) | (&pp[3:1] & gg[0]) | (&pp & ci);
  end
  always_comb begin
    Sum = Enable ? (p ^ c[ALU_W-1:0]) : '0;
    CO  = Enable & c[ALU_W];
  end
endmodule

// File: rtl/g_mul_seq32.sv
// g_mul_seq32: 32x32 unsigned shift-add multiplier, one adder pass per cycle
import g_alu_pkg::*;
module g_mul_seq32 (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               Start,
  input  logic [ALU_W-1:0]   In1,
  input  logic [ALU_W-1:0]   In2,
  output logic               Busy,
  output logic               Done,
  output logic [2*ALU_W-1:0] Out
);
  mul_state_t state_q, state_d;
  logic [MUL_CNT_W-1:0] cnt_q, cnt_d;
  logic [ALU_W-1:0] m_q, m_d, sum;
  logic [2*ALU_W-1:0] p_q, p_d, out_q, out_d, p_next;
  logic co, accept, run, last;
  G_FullAdder32 u_add (
    .In1    (p_q[2*ALU_W-1:ALU_W]),
    .In2    (p_q[0] ? m_q : '0),
    .CI     (1'b0),
    .Enable (1'b1),
    .Sum    (sum),
    .CO     (co)
  );
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      p_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      p_q     <= p_d;
      out_q   <= out_d;
    end
  end
  always_comb begin
    accept  = Start && state_q != RUN;
    run     = state_q == RUN;
    last    = run && cnt_q == '1;
    state_d = accept ? RUN : last ? DONE : run ? RUN : IDLE;
  end
  // carry-out goes in as bit 63 so the 33-bit partial sum is never truncated
  always_comb begin
    p_next = {co, sum, p_q[ALU_W-1:1]};
    m_d    = accept ? In1 : m_q;
    p_d    = accept ? {{ALU_W{1'b0}}, In2} : run ? p_next : p_q;
    cnt_d  = accept ? '0 : run ? cnt_q + 1'b1 : cnt_q;
    out_d  = last ? p_next : out_q;
  end
  always_comb begin
    Busy = state_q == RUN;
    Done = state_q == DONE;
  end
  assign Out = out_q;
endmodule

// File: tb/tb_g_mul_seq32.sv
// tb_g_mul_seq32: directed checks of the sequential multiplier
`timescale 1ns/1ps
module tb_g_mul_seq32;
  logic CLK = 0, RST_N = 0, Start = 0;
  logic [31:0] In1 = 0, In2 = 0;
  logic Busy, Done;
  logic [63:0] Out;
  int total = 0, fails = 0;

  g_mul_seq32 dut (.CLK(CLK), .RST_N(RST_N), .Start(Start), .In1(In1), .In2(In2),
                   .Busy(Busy), .Done(Done), .Out(Out));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    In1 = a; In2 = b; Start = 1;
    @(posedge CLK); #1;
    Start = 0;
  endtask

  // sampled #1 after the accepting edge; ends #1 after the edge that enters DONE
  task automatic finish_op(input string tag, input logic [63:0] exp, input int inject);
    int nb = 0, nd = 0, moved = 0;
    logic [63:0] held;
    held = Out;
    for (int j = 0; j < 32; j++) begin
      if (Busy) nb++;
      if (Done) nd++;
      if (Out !== held) moved++;
      if (j == inject) begin In1 = 32'h9; In2 = 32'h9; Start = 1; end
      @(posedge CLK); #1;
      Start = 0;
    end
    chk({tag, "_busy_cycles"}, 64'(nb), 64'd32);
    chk({tag, "_no_early_done"}, 64'(nd), 64'd0);
    chk({tag, "_out_stable"}, 64'(moved), 64'd0);
    chk({tag, "_done"}, {63'd0, Done}, 64'd1);
    chk({tag, "_busy_off"}, {63'd0, Busy}, 64'd0);
    chk({tag, "_out"}, Out, exp);
  endtask

  task automatic idle_chk(input string tag);
    @(posedge CLK); #1;
    chk({tag, "_done_drop"}, {63'd0, Done}, 64'd0);
    chk({tag, "_idle_busy"}, {63'd0, Busy}, 64'd0);
  endtask

  initial begin
    #1;
    chk("rst_busy", {63'd0, Busy}, 64'd0);
    chk("rst_done", {63'd0, Done}, 64'd0);
    chk("rst_out", Out, 64'd0);
    #20 RST_N = 1;
    @(posedge CLK); #1;

    start_op(32'h3, 32'h5);
    finish_op("3x5", 64'hF, -1);
    idle_chk("3x5");

    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("max", 64'hFFFF_FFFE_0000_0001, -1);
    idle_chk("max");

    start_op(32'h0, 32'hDEAD_BEEF);
    finish_op("zero", 64'h0, -1);
    idle_chk("zero");

    start_op(32'h8000_0000, 32'h2);
    finish_op("msb", 64'h1_0000_0000, -1);
    idle_chk("msb");

    start_op(32'h1234_5678, 32'h10);
    finish_op("ignore", 64'h1_2345_6780, 9);
    idle_chk("ignore");

    start_op(32'h7, 32'h7);
    repeat (10) begin @(posedge CLK); #1; end
    chk("abort_running", {63'd0, Busy}, 64'd1);
    #2 RST_N = 0;
    #1;
    chk("abort_busy", {63'd0, Busy}, 64'd0);
    chk("abort_done", {63'd0, Done}, 64'd0);
    chk("abort_out", Out, 64'd0);
    @(negedge CLK); RST_N = 1;
    @(posedge CLK); #1;
    chk("abort_no_done", {63'd0, Done}, 64'd0);
    start_op(32'h7, 32'h6);
    finish_op("7x6", 64'h2A, -1);
    idle_chk("7x6");

    start_op(32'h5, 32'h7);
    finish_op("b2b_a", 64'h23, -1);
    start_op(32'h2, 32'h3);
    chk("b2b_no_gap", {63'd0, Busy}, 64'd1);
    chk("b2b_hold", Out, 64'h23);
    finish_op("b2b_b", 64'h6, -1);
    idle_chk("b2b_b");

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
